// File: rtl/conv3d_ctrl.sv
// conv3d_ctrl: sequencing FSM for the 3-channel 3D-convolution datapath (load, then two filter passes).
// Optional stall counter output is enabled by defining CONV3D_CTRL_STALL_CNT_EN.
module conv3d_ctrl #(
  parameter int unsigned ACT_WORDS = 81,
  parameter int unsigned FLT_WORDS = 9,
  parameter int unsigned MAC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        one_window_done,
  input  logic        one_row_done,
  input  logic        done_row,
  output logic        rst_data,
  output logic        rst_mac,
  output logic        rst_cnt_col,
  output logic        rst_cnt_row,
  output logic        rst_cnt_win,
  output logic        ld,
  output logic        lf_0,
  output logic        lf_1,
  output logic        cen_cnt_win,
  output logic        l_mac,
  output logic        sel,
  output logic        y_valid,
  input  logic        y_ready,
  output logic        y_last,
`ifdef CONV3D_CTRL_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        busy,
  output logic        done
);

  localparam int unsigned TotalWords = ACT_WORDS + 2 * FLT_WORDS;
  localparam int unsigned LcW        = $clog2(TotalWords + 1);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StInit  = 4'd1;
  localparam logic [3:0] StLoad  = 4'd2;
  localparam logic [3:0] StClr   = 4'd3;
  localparam logic [3:0] StComp  = 4'd4;
  localparam logic [3:0] StDrain = 4'd5;
  localparam logic [3:0] StOut   = 4'd6;
  localparam logic [3:0] StSwap  = 4'd7;
  localparam logic [3:0] StFin   = 4'd8;

  logic [3:0]     state_q, state_d;
  logic [LcW-1:0] lc_q, lc_d;
  logic [1:0]     dc_q, dc_d;
  logic           sel_q, sel_d;
  logic           last_win_q, last_win_d;

  assign sel = sel_q;

  always_comb begin
    state_d     = state_q;
    lc_d        = lc_q;
    dc_d        = dc_q;
    sel_d       = sel_q;
    last_win_d  = last_win_q;
    rst_data    = 1'b0;
    rst_mac     = 1'b0;
    rst_cnt_col = 1'b0;
    rst_cnt_row = 1'b0;
    rst_cnt_win = 1'b0;
    ld          = 1'b0;
    lf_0        = 1'b0;
    lf_1        = 1'b0;
    cen_cnt_win = 1'b0;
    l_mac       = 1'b0;
    s_ready     = 1'b0;
    y_valid     = 1'b0;
    y_last      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy        = 1'b0;
        rst_data    = 1'b1;
        rst_mac     = 1'b1;
        rst_cnt_col = 1'b1;
        rst_cnt_row = 1'b1;
        rst_cnt_win = 1'b1;
        if (start) state_d = StInit;
      end
      StInit: begin
        rst_data    = 1'b1;
        rst_mac     = 1'b1;
        rst_cnt_col = 1'b1;
        rst_cnt_row = 1'b1;
        rst_cnt_win = 1'b1;
        lc_d        = '0;
        state_d     = StLoad;
      end
      StLoad: begin
        rst_mac     = 1'b1;
        rst_cnt_col = 1'b1;
        rst_cnt_row = 1'b1;
        rst_cnt_win = 1'b1;
        s_ready     = 1'b1;
        if (s_valid) begin
          // Word order on the stream: activations, then filter 0, then filter 1.
          if (32'(lc_q) < ACT_WORDS)                  ld   = 1'b1;
          else if (32'(lc_q) < ACT_WORDS + FLT_WORDS) lf_0 = 1'b1;
          else                                        lf_1 = 1'b1;
          lc_d = lc_q + LcW'(1);
          if (32'(lc_q) == TotalWords - 1) state_d = StClr;
        end
      end
      StClr: begin
        rst_mac     = 1'b1;
        rst_cnt_win = 1'b1;
        state_d     = StComp;
      end
      StComp: begin
        cen_cnt_win = 1'b1;
        l_mac       = 1'b1;
        if (one_window_done) begin
          last_win_d = one_row_done & done_row;
          dc_d       = '0;
          state_d    = (MAC_LAT == 0) ? StOut : StDrain;
        end
      end
      StDrain: begin
        if (dc_q == 2'(MAC_LAT - 1)) state_d = StOut;
        else                          dc_d    = dc_q + 2'd1;
      end
      StOut: begin
        y_valid = 1'b1;
        y_last  = last_win_q;
        if (y_ready) begin
          if (!last_win_q) state_d = StClr;
          else if (!sel_q) state_d = StSwap;
          else             state_d = StFin;
        end
      end
      StSwap: begin
        // Second pass reuses the loaded activations and filters; only counters and MAC restart.
        rst_mac     = 1'b1;
        rst_cnt_col = 1'b1;
        rst_cnt_row = 1'b1;
        rst_cnt_win = 1'b1;
        sel_d       = 1'b1;
        last_win_d  = 1'b0;
        state_d     = StClr;
      end
      StFin: begin
        busy        = 1'b0;
        done        = 1'b1;
        rst_mac     = 1'b1;
        rst_cnt_col = 1'b1;
        rst_cnt_row = 1'b1;
        rst_cnt_win = 1'b1;
        sel_d       = 1'b0;
        last_win_d  = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lc_q       <= '0;
      dc_q       <= '0;
      sel_q      <= 1'b0;
      last_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      dc_q       <= dc_d;
      sel_q      <= sel_d;
      last_win_q <= last_win_d;
    end
  end

`ifdef CONV3D_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StInit) begin
      stall_d = '0;
    end else if (((state_q == StLoad && !s_valid) || (state_q == StOut && !y_ready)) &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`endif

endmodule
